echo_effect: RTL and testbench

Audio effect stage between the SPI receive block (comunication) and the DAC driver (dac_driver), alongside eff_1.
- Consumes each 16-bit signed sample announced by data_ready.
- Mixes the sample with an attenuated copy taken DELAY_DEPTH samples earlier from an internal circular delay line (feedback echo).
- Presents the result on audio_out with a one-cycle process_status pulse. When enable is low the block is a transparent bypass with identical latency.

---
 rtl/echo_effect.sv | 161 ++++++++++++++++
 tb/tb_echo_effect.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_effect.sv
// echo_effect: feedback echo stage for the audio path.
// Each accepted sample is mixed with an attenuated copy of the sample written
// DELAY_DEPTH samples earlier. The delay line is a circular buffer in a
// synchronous-read RAM. When enable is low, the block passes samples through
// with the same latency and still records them in the delay line.
module echo_effect #(
    parameter int clock_max      = 25_000_000,
    parameter int DELAY_DEPTH    = 4096,
    parameter int FEEDBACK_SHIFT = 1
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic               data_ready,
    input  logic signed [15:0] audio_in,
    input  logic               enable,
    output logic signed [15:0] audio_out,
    output logic               process_status,
    output logic               busy,
    output logic               overrun
);

    localparam int PTR_W  = $clog2(DELAY_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    // Reject parameter values the datapath cannot support at elaboration time
    if (DELAY_DEPTH < 4 || DELAY_DEPTH > 8192 || (DELAY_DEPTH & (DELAY_DEPTH - 1)) != 0 ||
        FEEDBACK_SHIFT < 1 || FEEDBACK_SHIFT > 4 || clock_max < 1) begin : g_bad_params
        $error("echo_effect: unsupported parameter value");
    end

    typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} state_t;

    state_t              state_q, state_d;
    logic                dr_q, dr_d;
    logic signed [15:0]  x_q, x_d;
    logic                en_q, en_d;
    logic signed [15:0]  d_q, d_d;
    logic signed [15:0]  y_q, y_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic signed [15:0]  out_q, out_d;
    logic                ps_q, ps_d;
    logic                overrun_q, overrun_d;

    logic signed [15:0]  mem [DELAY_DEPTH];
    logic signed [15:0]  ram_rd_q;

    logic                rise;
    logic                accept;
    logic                ram_re;
    logic                ram_we;
    logic signed [15:0]  echo_term;
    logic        [16:0]  sum17;
    logic signed [15:0]  mixed;

    // Rising edge of data_ready; it only starts work when the FSM is idle
    always_comb begin
        rise   = data_ready & ~dr_q;
        accept = rise & (state_q == IDLE);
        ram_re = accept;
        ram_we = (state_q == WRITE);
    end

    // Attenuated echo plus dry sample, saturated when the 17-bit sum overflows 16 bits
    always_comb begin
        echo_term = d_q >>> FEEDBACK_SHIFT;
        sum17     = {x_q[15], x_q} + {echo_term[15], echo_term};
        if (sum17[16] != sum17[15]) begin
            mixed = sum17[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            mixed = sum17[15:0];
        end
    end

    // Next-state logic for the IDLE -> READ -> MIX -> WRITE sequence
    always_comb begin
        state_d   = state_q;
        dr_d      = data_ready;
        x_d       = x_q;
        en_d      = en_q;
        d_d       = d_q;
        y_d       = y_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        out_d     = out_q;
        ps_d      = 1'b0;
        overrun_d = overrun_q | (rise & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = audio_in;
                    en_d    = enable;
                    state_d = READ;
                end
            end
            READ: begin
                d_d     = (fill_q < FILL_W'(DELAY_DEPTH)) ? 16'sd0 : ram_rd_q;
                state_d = MIX;
            end
            MIX: begin
                y_d     = en_q ? mixed : x_q;
                state_d = WRITE;
            end
            WRITE: begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DELAY_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                if (fill_q < FILL_W'(DELAY_DEPTH)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                out_d   = y_q;
                ps_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset drops any in-flight sample
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dr_q      <= 1'b0;
            x_q       <= '0;
            en_q      <= 1'b0;
            d_q       <= '0;
            y_q       <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            out_q     <= '0;
            ps_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dr_q      <= dr_d;
            x_q       <= x_d;
            en_q      <= en_d;
            d_q       <= d_d;
            y_q       <= y_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            ps_q      <= ps_d;
            overrun_q <= overrun_d;
        end
    end

    // Delay line RAM: read only on acceptance, write only in WRITE, never cleared
    always_ff @(posedge clk_25mhz) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= y_q;
        end
        if (ram_re) begin
            ram_rd_q <= mem[wr_ptr_q];
        end
    end

    assign audio_out      = out_q;
    assign process_status = ps_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_echo_effect.sv
// tb_echo_effect: directed scoreboard bench for echo_effect with a 4-sample delay line.
module tb_echo_effect;

   logic               clk_25mhz;
   logic               reset;
   logic               data_ready;
   logic signed [15:0] audio_in;
   logic               enable;
   logic signed [15:0] audio_out;
   logic               process_status;
   logic               busy;
   logic               overrun;

   int vectorCount;
   int missCount;
   int pulseCount;
   logic signed [15:0] expectQueue [$];

   echo_effect #(
      .clock_max(25_000_000),
      .DELAY_DEPTH(4),
      .FEEDBACK_SHIFT(1)
   ) dut (
      .clk_25mhz(clk_25mhz),
      .reset(reset),
      .data_ready(data_ready),
      .audio_in(audio_in),
      .enable(enable),
      .audio_out(audio_out),
      .process_status(process_status),
      .busy(busy),
      .overrun(overrun)
   );

   // 100 MHz-style free-running bench clock; period is arbitrary for the DUT
   initial begin
      clk_25mhz = 1'b0;
      forever #5 clk_25mhz = ~clk_25mhz;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input int actual, input int expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Issue one sample edge; optionally queue its expected result for the monitor
   task automatic applyStimulus(input logic signed [15:0] value, input logic en,
                                input logic signed [15:0] expected, input bit push);
      @(negedge clk_25mhz);
      audio_in   = value;
      enable     = en;
      data_ready = 1'b1;
      if (push) expectQueue.push_back(expected);
      @(negedge clk_25mhz);
      data_ready = 1'b0;
      repeat (4) @(negedge clk_25mhz);
   endtask

   // Hold reset across a couple of clocks and release it away from the edge
   task automatic doReset();
      @(negedge clk_25mhz);
      reset = 1'b1;
      repeat (2) @(negedge clk_25mhz);
      reset = 1'b0;
   endtask

   // Scoreboard monitor: every process_status pulse must match the next queued result
   always @(negedge clk_25mhz) begin
      if (!reset && process_status) begin
         pulseCount++;
         if (expectQueue.size() == 0) begin
            checkOutput("unexpected_pulse", int'(audio_out), 99999);
         end else begin
            checkOutput("audio_out", int'(audio_out), int'(expectQueue.pop_front()));
         end
      end
   end

   initial begin
      vectorCount = 0;
      missCount   = 0;
      pulseCount  = 0;
      reset       = 1'b1;
      data_ready  = 1'b0;
      audio_in    = '0;
      enable      = 1'b1;
      repeat (3) @(negedge clk_25mhz);
      reset = 1'b0;

      checkOutput("reset_audio_out", int'(audio_out), 0);
      checkOutput("reset_status", int'(process_status), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_overrun", int'(overrun), 0);

      // Latency of the first sample: edge N, result at N+3 only
      @(negedge clk_25mhz);
      audio_in   = 16'sd1000;
      enable     = 1'b1;
      data_ready = 1'b1;
      expectQueue.push_back(16'sd1000);
      @(posedge clk_25mhz); #1;
      data_ready = 1'b0;
      checkOutput("lat_n0_status", int'(process_status), 0);
      checkOutput("lat_n0_busy", int'(busy), 1);
      @(posedge clk_25mhz); #1;
      checkOutput("lat_n1_status", int'(process_status), 0);
      checkOutput("lat_n1_busy", int'(busy), 1);
      @(posedge clk_25mhz); #1;
      checkOutput("lat_n2_status", int'(process_status), 0);
      checkOutput("lat_n2_busy", int'(busy), 1);
      @(posedge clk_25mhz); #1;
      checkOutput("lat_n3_status", int'(process_status), 1);
      checkOutput("lat_n3_audio", int'(audio_out), 1000);
      checkOutput("lat_n3_busy", int'(busy), 0);
      @(posedge clk_25mhz); #1;
      checkOutput("lat_n4_status", int'(process_status), 0);

      // Echo decay: 1000 then zeros gives 500 after 4 samples, 250 after 8
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd500, 1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd0,   1'b1);
      applyStimulus(16'sd0, 1'b1, 16'sd250, 1'b1);

      // Reset in the middle of a sample: outputs clear at once, no pulse
      @(negedge clk_25mhz);
      audio_in   = 16'sd555;
      data_ready = 1'b1;
      @(negedge clk_25mhz);
      data_ready = 1'b0;
      @(posedge clk_25mhz); #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_audio_out", int'(audio_out), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_status", int'(process_status), 0);
      @(negedge clk_25mhz);
      reset = 1'b0;

      // Fill counter cleared: stale RAM is ignored for the first four samples
      applyStimulus(16'sd7, 1'b1, 16'sd7,  1'b1);
      applyStimulus(16'sd7, 1'b1, 16'sd7,  1'b1);
      applyStimulus(16'sd7, 1'b1, 16'sd7,  1'b1);
      applyStimulus(16'sd7, 1'b1, 16'sd7,  1'b1);
      applyStimulus(16'sd7, 1'b1, 16'sd10, 1'b1);

      // Bypass with a full delay line, then a dropped edge during -5
      applyStimulus(16'sd1234, 1'b0, 16'sd1234, 1'b1);
      checkOutput("overrun_before", int'(overrun), 0);
      @(negedge clk_25mhz);
      audio_in   = -16'sd5;
      enable     = 1'b0;
      data_ready = 1'b1;
      expectQueue.push_back(-16'sd5);
      @(negedge clk_25mhz);
      data_ready = 1'b0;
      @(negedge clk_25mhz);
      audio_in   = 16'sd999;
      data_ready = 1'b1;
      @(negedge clk_25mhz);
      data_ready = 1'b0;
      repeat (4) @(negedge clk_25mhz);
      checkOutput("overrun_after", int'(overrun), 1);

      // Echo enabled again: bypassed samples now contribute their history
      applyStimulus(16'sd0,   1'b1, 16'sd3,   1'b1);
      applyStimulus(16'sd0,   1'b1, 16'sd5,   1'b1);
      applyStimulus(16'sd100, 1'b1, 16'sd717, 1'b1);

      // Held-high data_ready yields exactly one result
      begin
         int startPulses;
         startPulses = pulseCount;
         @(negedge clk_25mhz);
         audio_in   = 16'sd42;
         enable     = 1'b1;
         data_ready = 1'b1;
         expectQueue.push_back(16'sd39);
         repeat (10) @(negedge clk_25mhz);
         data_ready = 1'b0;
         repeat (4) @(negedge clk_25mhz);
         checkOutput("held_level_pulses", pulseCount - startPulses, 1);
      end

      // Positive saturation
      doReset();
      applyStimulus(16'sd30000, 1'b1, 16'sd30000, 1'b1);
      applyStimulus(16'sd0,     1'b1, 16'sd0,     1'b1);
      applyStimulus(16'sd0,     1'b1, 16'sd0,     1'b1);
      applyStimulus(16'sd0,     1'b1, 16'sd0,     1'b1);
      applyStimulus(16'sd30000, 1'b1, 16'sd32767, 1'b1);

      // Negative saturation
      doReset();
      applyStimulus(-16'sd30000, 1'b1, -16'sd30000, 1'b1);
      applyStimulus(16'sd0,      1'b1, 16'sd0,      1'b1);
      applyStimulus(16'sd0,      1'b1, 16'sd0,      1'b1);
      applyStimulus(16'sd0,      1'b1, 16'sd0,      1'b1);
      applyStimulus(-16'sd30000, 1'b1, -16'sh8000,  1'b1);

      repeat (4) @(negedge clk_25mhz);
      checkOutput("results_outstanding", expectQueue.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
